fifo_burst_sched: RTL and testbench

- Sequences the 8-bit-in / 256-bit-out feature FIFO.
- Write side: accepts an upstream byte stream and gates the FIFO write enable against full.
- Read side: watches the write-side water level and drains fixed-length bursts of 256-bit words to a downstream valid/ready consumer (DDR writer or PE array), flushing the remainder at frame end.
- Sits between the line/pixel packer and the FIFO instance; owns every FIFO enable.

---
 rtl/fifo_sched_pkg.sv | 20 ++
 rtl/skid_buf2.sv | 79 +++++++
 rtl/fifo_burst_sched.sv | 134 +++++++++++++
 tb/tb_fifo_burst_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the feature-FIFO burst scheduler.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int BYTES_PER_WORD = 32;
    localparam int WORD_SHIFT     = 5;
    localparam int BURST_LEN_DEF  = 8;
    localparam int CNT_W          = 6;

    function automatic logic [CNT_W-1:0] min_words(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer that absorbs the one-cycle FIFO read latency;
// the credit output tells the issuer whether another read can be launched.
module skid_buf2 #(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_i,
    input  logic          tag_i,
    input  logic [DW-1:0] data_i,
    output logic          credit_o,
    output logic          idle_o,
    output logic          out_valid_o,
    output logic          out_last_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i
);

    logic          inflight_q;
    logic          inflight_tag_q;
    logic [1:0]    cnt_q;
    logic [DW:0]   e0_q;
    logic [DW:0]   e1_q;
    logic          push_s;
    logic          pop_s;
    logic [DW:0]   new_s;

    // Credit counts this cycle's pop so a steady stream keeps one word per cycle.
    always_comb begin
        push_s      = inflight_q;
        pop_s       = (cnt_q != 2'd0) & out_ready_i;
        new_s       = {inflight_tag_q, data_i};
        credit_o    = ({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s});
        idle_o      = (cnt_q == 2'd0) & ~inflight_q;
        out_valid_o = (cnt_q != 2'd0);
        out_last_o  = e0_q[DW];
        out_data_o  = e0_q[DW-1:0];
    end

    // Entry storage: e0 is the head presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            inflight_tag_q <= 1'b0;
            cnt_q          <= 2'd0;
            e0_q           <= {(DW+1){1'b0}};
            e1_q           <= {(DW+1){1'b0}};
        end else begin
            inflight_q     <= issue_i;
            inflight_tag_q <= tag_i;
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_q <= new_s;
                    end else begin
                        e1_q <= new_s;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_q <= new_s;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= new_s;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_sched.sv
// Owns every enable of the 8-in/256-out feature FIFO: gates writes against
// full and drains fixed-length read bursts, flushing the tail at frame end.
module fifo_burst_sched
    import fifo_sched_pkg::*;
#(
    parameter int BURST_LEN      = 8,
    parameter int LEVEL_W        = 11,
    parameter int BYTES_PER_WORD = fifo_sched_pkg::BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               fifo_wr_en,
    output logic [7:0]         fifo_wr_data,
    input  logic               fifo_full,
    input  logic [LEVEL_W-1:0] fifo_wr_water_level,
    output logic               fifo_rd_en,
    input  logic [255:0]       fifo_rd_data,
    input  logic               fifo_empty,
    output logic               m_valid,
    output logic [255:0]       m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               frame_done,
    output logic               busy
);

    localparam int                 SHIFT        = $clog2(BYTES_PER_WORD);
    localparam logic [LEVEL_W-1:0] BURST_LEN_LV = LEVEL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]   BURST_LEN_C  = CNT_W'(BURST_LEN);

    state_e             state_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   issued_q;
    logic               flush_pending_q;
    logic               frame_done_q;
    logic               run_q;

    logic [LEVEL_W-1:0] avail_s;
    logic               accept_last_s;
    logic               start_norm_s;
    logic               start_flush_s;
    logic               done_fire_s;
    logic               rd_en_s;
    logic               last_tag_s;
    logic               credit_s;
    logic               buf_idle_s;

    // Write gating, burst start decisions and read issue.
    always_comb begin
        s_ready       = run_q & ~fifo_full;
        fifo_wr_en    = s_valid & run_q & ~fifo_full;
        fifo_wr_data  = s_data;
        accept_last_s = s_valid & run_q & ~fifo_full & s_last;
        avail_s       = fifo_wr_water_level >> SHIFT;
        start_norm_s  = (state_q == IDLE) & (avail_s >= BURST_LEN_LV);
        start_flush_s = (state_q == IDLE) & ~start_norm_s & flush_pending_q
                        & (avail_s != {LEVEL_W{1'b0}});
        done_fire_s   = (state_q == IDLE) & ~start_norm_s & ~start_flush_s
                        & flush_pending_q & fifo_empty & buf_idle_s;
        rd_en_s       = (state_q == BURST) & ~fifo_empty & (issued_q < target_q) & credit_s;
        last_tag_s    = ((issued_q + 6'd1) == target_q);
        fifo_rd_en    = rd_en_s;
        frame_done    = frame_done_q;
        busy          = (state_q != IDLE) | flush_pending_q;
    end

    skid_buf2 #(.DW(256)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_i     (rd_en_s),
        .tag_i       (last_tag_s),
        .data_i      (fifo_rd_data),
        .credit_o    (credit_s),
        .idle_o      (buf_idle_s),
        .out_valid_o (m_valid),
        .out_last_o  (m_last),
        .out_data_o  (m_data),
        .out_ready_i (m_ready)
    );

    // Burst FSM; a flush that arrives as a normal burst starts waits for the next IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            target_q        <= {CNT_W{1'b0}};
            issued_q        <= {CNT_W{1'b0}};
            flush_pending_q <= 1'b0;
            frame_done_q    <= 1'b0;
            run_q           <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            frame_done_q <= done_fire_s;
            if (accept_last_s) begin
                flush_pending_q <= 1'b1;
            end else if (done_fire_s) begin
                flush_pending_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_norm_s) begin
                        state_q  <= BURST;
                        target_q <= BURST_LEN_C;
                        issued_q <= {CNT_W{1'b0}};
                    end else if (start_flush_s) begin
                        state_q  <= BURST;
                        target_q <= min_words(BURST_LEN_C, avail_s[CNT_W-1:0]);
                        issued_q <= {CNT_W{1'b0}};
                    end
                end
                BURST: begin
                    if (rd_en_s) begin
                        issued_q <= issued_q + 6'd1;
                    end
                    if (issued_q == target_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_valid & m_ready & m_last) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Directed bench for fifo_burst_sched with a behavioural byte-in/word-out FIFO.
module tb_fifo_burst_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid, s_last, s_ready;
    logic [7:0]   s_data;
    logic         fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
    logic [7:0]   fifo_wr_data;
    logic [10:0]  fifo_wr_water_level;
    logic [255:0] fifo_rd_data;
    logic         m_valid, m_last, m_ready, frame_done, busy;
    logic [255:0] m_data;

    fifo_burst_sched dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .fifo_wr_water_level(fifo_wr_water_level),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: bytes in, 32-byte words out, byte 0 in bits [7:0].
    logic [7:0] fq[$];
    logic       force_full;
    logic       fifo_clr;
    assign fifo_full  = force_full | (fifo_wr_water_level >= 11'd2016);
    assign fifo_empty = (fifo_wr_water_level < 11'd32);

    always @(posedge clk) begin
        logic [255:0] w;
        w = '0;
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_wr_en) fq.push_back(fifo_wr_data);
            if (fifo_rd_en) begin
                for (int k = 0; k < 32; k++) w[8*k +: 8] = fq.pop_front();
                fifo_rd_data <= w;
            end
        end
        fifo_wr_water_level <= fifo_clr ? 11'd0 : 11'(fq.size());
    end

    // Output monitor
    logic [255:0] got_w[$];
    logic         got_l[$];
    int           acc_cnt = 0, rd_cnt = 0, done_cnt = 0, max_out = 0, stab_err = 0;
    logic         prev_stall = 1'b0, prev_last = 1'b0;
    logic [255:0] prev_data = '0;

    always @(negedge clk) begin
        int acc, rd;
        acc = (m_valid && m_ready) ? 1 : 0;
        rd  = fifo_rd_en ? 1 : 0;
        if (!rst_n) begin
            rd_cnt     <= acc_cnt;
            prev_stall <= 1'b0;
        end else begin
            if (acc == 1) begin
                got_w.push_back(m_data);
                got_l.push_back(m_last);
            end
            acc_cnt <= acc_cnt + acc;
            rd_cnt  <= rd_cnt + rd;
            if ((rd_cnt + rd) - (acc_cnt + acc) > max_out) max_out <= (rd_cnt + rd) - (acc_cnt + acc);
            if (frame_done) done_cnt <= done_cnt + 1;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stab_err <= stab_err + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int f, input int i);
        return 8'((i + f * 17 + (i / 256) * 101) & 255);
    endfunction

    function automatic logic [255:0] word_of(input int f, input int w);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = pat(f, 32 * w + k);
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, 256'(s_ready), 256'd0);
        chk({tag, "_wr_en"}, 256'(fifo_wr_en), 256'd0);
        chk({tag, "_rd_en"}, 256'(fifo_rd_en), 256'd0);
        chk({tag, "_m_valid"}, 256'(m_valid), 256'd0);
        chk({tag, "_m_last"}, 256'(m_last), 256'd0);
        chk({tag, "_frame_done"}, 256'(frame_done), 256'd0);
        chk({tag, "_busy"}, 256'(busy), 256'd0);
        chk({tag, "_m_data"}, m_data, 256'd0);
    endtask

    // Send one frame byte by byte; optionally hold the FIFO full before byte full_at.
    task automatic send_frame(input int f, input int nbytes, input int full_at);
        logic ok;
        int   tmo;
        for (int i = 0; i < nbytes; i++) begin
            s_valid = 1'b1;
            s_data  = pat(f, i);
            s_last  = (i == nbytes - 1);
            if (i == full_at) begin
                force_full = 1'b1;
                @(negedge clk);
                chk("full_s_ready", 256'(s_ready), 256'd0);
                chk("full_wr_en", 256'(fifo_wr_en), 256'd0);
                repeat (3) @(posedge clk);
                #1 force_full = 1'b0;
            end
            tmo = 0;
            ok  = 1'b0;
            while (!ok && tmo < 200) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk);
                #1 tmo++;
            end
            if (!ok) chk("send_timeout", 256'd0, 256'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            @(posedge clk);
            #1 t++;
        end
        if (done_cnt < target) chk("done_timeout", 256'(done_cnt), 256'(target));
    endtask

    // Check a delivered frame: bursts of 8, last word closes the tail burst.
    task automatic check_frame(input string tag, input int f, input int nbytes,
                               input int base, input int done_base);
        int nw;
        nw = nbytes / 32;
        wait_done(done_base + 1);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_nwords"}, 256'(got_w.size() - base), 256'(nw));
        for (int w = 0; w < nw; w++) begin
            if (base + w < got_w.size()) begin
                chk($sformatf("%s_data%0d", tag, w), got_w[base + w], word_of(f, w));
                chk($sformatf("%s_last%0d", tag, w), 256'(got_l[base + w]),
                    256'((w % 8 == 7) || (w == nw - 1)));
            end
        end
        chk({tag, "_done_cnt"}, 256'(done_cnt - done_base), 256'd1);
        chk({tag, "_busy"}, 256'(busy), 256'd0);
    endtask

    initial begin
        int base, dbase, t;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'd0;
        m_ready = 1'b1; force_full = 1'b0; fifo_clr = 1'b1;
        #3 chk_reset("rst0");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; fifo_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        base = got_w.size(); dbase = done_cnt;
        send_frame(1, 256, -1);
        check_frame("f256", 1, 256, base, dbase);

        base = got_w.size(); dbase = done_cnt;
        send_frame(2, 96, 40);
        check_frame("f96", 2, 96, base, dbase);

        base = got_w.size(); dbase = done_cnt;
        send_frame(3, 640, -1);
        check_frame("f640", 3, 640, base, dbase);

        base = got_w.size(); dbase = done_cnt;
        send_frame(4, 256, -1);
        t = 0;
        while (got_w.size() < base + 2 && t < 200) begin
            @(posedge clk);
            #1 t++;
        end
        m_ready = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("stall_m_valid", 256'(m_valid), 256'd1);
        chk("stall_words", 256'(got_w.size() - base), 256'd2);
        @(posedge clk);
        #1 m_ready = 1'b1;
        check_frame("stall", 4, 256, base, dbase);

        base = got_w.size();
        send_frame(5, 256, -1);
        t = 0;
        while (got_w.size() < base + 4 && t < 200) begin
            @(posedge clk);
            #1 t++;
        end
        chk("pre_rst_busy", 256'(busy), 256'd1);
        rst_n = 1'b0; fifo_clr = 1'b1;
        #1 chk_reset("rst_mid");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; fifo_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = got_w.size(); dbase = done_cnt;
        send_frame(6, 256, -1);
        check_frame("post_rst", 6, 256, base, dbase);

        chk("stable_hold_errs", 256'(stab_err), 256'd0);
        chk("max_outstanding_le2", 256'(max_out <= 2), 256'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
